imem_loader_ram: RTL
====================

# imem_loader_ram

Parametrised instruction memory for the 6502 core with a built-in program loader and a self-clearing reset sequence. Replaces the fixed 16×1024 instruction RAM. A synchronous clear state machine zeroes one word per cycle after reset, a valid/ready load port streams program words into consecutive addresses, and a registered fetch port serves the core's instruction fetch. It sits between the external program source (testbench or boot ROM streamer) and the core fetch stage.

## Interface
Parameters:
- DATA_W, 16, instruction word width
- DEPTH, 1024, number of words; must be a power of two
- ADDR_W, $clog2(DEPTH), address width

Ports:
- clk  in  1  single clock; all logic is clocked on the rising edge
- reset  in  1  synchronous, active-high; forces state CLEAR with clear pointer 0
- load_start  in  1  single-cycle request to begin a load; honoured only in IDLE
- load_base  in  ADDR_W  first write address; sampled with load_start
- load_valid  in  1  load beat valid
- load_data  in  DATA_W  load beat data
- load_last  in  1  marks the final beat; qualified by load_valid & load_ready
- load_ready  out  1  high only in LOAD
- load_done  out  1  one-cycle pulse after the last beat is written
- fetch_req  in  1  fetch request; honoured only in IDLE
- fetch_addr  in  ADDR_W  fetch address
- fetch_data  out  DATA_W  fetched word; holds its value when no fetch completes
- fetch_valid  out  1  fetch_data is valid this cycle
- busy  out  1  high in CLEAR and LOAD
- parity_err  out  1  parity mismatch on the returned fetch word (see Configuration)

## Operation
- States: CLEAR, IDLE, LOAD.
- CLEAR: writes zero to mem[clr_ptr] each cycle and increments clr_ptr. After writing DEPTH-1 it moves to IDLE. load_start and fetch_req are ignored.
- IDLE: on fetch_req, reads mem[fetch_addr]. On load_start, latches load_base into wptr and moves to LOAD.
- If fetch_req and load_start are asserted in the same IDLE cycle, both take effect: the fetch completes normally and the state moves to LOAD.
- LOAD: load_ready=1. Each beat with load_valid & load_ready writes mem[wptr] and updates wptr to (wptr+1) mod DEPTH, so the address wraps from DEPTH-1 to 0. A beat with load_last writes its word and returns the state to IDLE.
- In LOAD, fetch_req is ignored (fetch_valid=0), and a further load_start is ignored.
- Reset in any state abandons the operation in progress: no load_done, and the clear sequence restarts from address 0. Words already loaded are overwritten by the clear.
- There is no load length limit. Loading more than DEPTH words overwrites earlier words in wrap order.

## Timing
- Reset values: busy=1, load_ready=0, load_done=0, fetch_valid=0, fetch_data=0, parity_err=0. State is CLEAR and clr_ptr=0.
- Clear duration: let cycle 0 be the first cycle with reset low. Address k is written in cycle k. busy falls and IDLE is entered in cycle DEPTH.
- Fetch latency is 1 cycle: a fetch_req accepted in cycle n gives fetch_data and fetch_valid=1 in cycle n+1. fetch_valid is a single-cycle pulse per request. Back-to-back requests give one valid word per cycle.
- Load: a beat accepted in cycle n is visible to a fetch issued in IDLE in cycle n+1 or later. The last beat is accepted in cycle n, load_done=1 in cycle n+1, and the state is IDLE in cycle n+1.
- load_ready is a registered state decode. It rises in the cycle after load_start.

## Configuration
- IMEM_PARITY_EN defined: storage is DATA_W+1 bits wide. Even parity is computed on every load write; clear writes parity 0. parity_err=1 in the fetch_valid cycle when the stored parity does not match the stored data, and is 0 otherwise.
- IMEM_PARITY_EN undefined: storage is DATA_W bits and parity_err is tied to 0. The port remains present.

## Structure
- Package imem_pkg: state enum imem_state_t {CLEAR, IDLE, LOAD}, default DATA_W/DEPTH constants, and the parity function.
- Sub-module imem_array: storage with one synchronous write port and one registered read port, parametrised in width and depth. The FSM, pointers and handshake logic live in the top.

## Test plan
- Reset for 2 cycles, then release -> busy=1 for exactly 1024 cycles. A fetch of 0x3FF afterwards returns 0x0000 with fetch_valid one cycle after fetch_req.
- load_start with base 0x010, beats 0xA901, 0x8D00, 0x0200, the last with load_last -> load_done pulses once, one cycle after the last beat. Fetch of 0x012 returns 0x0200.
- Wrap: base 0x3FF, beats 0x1111 then 0x2222 (last) -> mem[0x3FF]=0x1111 and mem[0x000]=0x2222.
- Backpressure: load_valid low on alternating cycles with fetch_req held high during LOAD -> only valid beats are written, consecutive addresses are used with no gaps, and fetch_valid stays 0 until IDLE.
- Reset after 1 beat of a 4-beat load -> load_done never asserts, busy stays high for 1024 cycles, and the loaded address reads 0x0000.
- With IMEM_PARITY_EN: load 0x00FF, then force-flip a data bit in the array and fetch -> parity_err=1 together with fetch_valid. An unmodified word gives parity_err=0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction memory loader.
// Holds the controller state encoding and the even-parity helper.
package imem_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 1024;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2
  } imem_state_t;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic parity_of(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Single-write, single-read word storage; read data registered, 1-cycle latency.
// No backpressure: a write or read presented on an edge always completes.
module imem_array #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register keeps its last word when no read is issued.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_loader_ram.sv
// Instruction RAM with clear-on-reset sequencer, valid/ready program loader and 1-cycle fetch.
// Loader stalls only on load_valid; fetches are ignored while busy. Optional parity: IMEM_PARITY_EN.
module imem_loader_ram
  import imem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              busy,
  output logic              parity_err
);

`ifdef IMEM_PARITY_EN
  localparam int STORE_W = DATA_W + 1;
`else
  localparam int STORE_W = DATA_W;
`endif

  imem_state_t       state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] wptr;
  logic              beat;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_waddr;
  logic [STORE_W-1:0] mem_wdata;
  logic [STORE_W-1:0] mem_rdata;

  // load_ready is only ever high in LOAD, so it doubles as the state qualifier.
  assign beat   = load_valid && load_ready;
  assign mem_re = (state == IDLE) && fetch_req;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_ptr;
    mem_wdata = '0;
    if (state == CLEAR) begin
      mem_we = 1'b1;
    end else if (beat) begin
      mem_we    = 1'b1;
      mem_waddr = wptr;
`ifdef IMEM_PARITY_EN
      mem_wdata = {parity_of(64'(load_data)), load_data};
`else
      mem_wdata = load_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR;
      clr_ptr     <= '0;
      wptr        <= '0;
      load_ready  <= 1'b0;
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;
      busy        <= 1'b1;
    end else begin
      load_done   <= 1'b0;
      fetch_valid <= mem_re;
      unique case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (load_start) begin
            wptr       <= load_base;
            state      <= LOAD;
            load_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (beat) begin
            wptr <= wptr + 1'b1;
            if (load_last) begin
              state      <= IDLE;
              load_ready <= 1'b0;
              busy       <= 1'b0;
              load_done  <= 1'b1;
            end
          end
        end
        default: begin
          state   <= CLEAR;
          clr_ptr <= '0;
          busy    <= 1'b1;
        end
      endcase
    end
  end

  imem_array #(
    .WIDTH (STORE_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .re   (mem_re),
    .raddr(fetch_addr),
    .rdata(mem_rdata)
  );

  assign fetch_data = mem_rdata[DATA_W-1:0];

`ifdef IMEM_PARITY_EN
  assign parity_err = fetch_valid && (mem_rdata[DATA_W] != (^mem_rdata[DATA_W-1:0]));
`else
  assign parity_err = 1'b0;
`endif

endmodule
